counter_share_arbiter: RTL and testbench
========================================

Name: counter_share_arbiter

Overview:
Shares one down-counting delay timer between NREQ requesters using round-robin arbitration.
- Each requester raises req with a delay length.
- The arbiter grants one requester, loads the shared counter, counts down to zero, then pulses done to the winner.
- Sits above the team's counter datapath as its sequencer/owner; all requesters see a single timer resource.

Parameters:
NREQ, 4, number of requesters (2..8)
CW, 4, counter width in bits; maximum delay is 2^CW-1 cycles

Ports:
clk  input  1  rising-edge clock for all state
reset  input  1  asynchronous, active-high; clears all state immediately
req  input  NREQ  per-requester request level; must stay high until done or the request aborts
len  input  NREQ*CW  per-requester delay; slice i is len[i*CW +: CW], sampled only at grant
gnt  output  NREQ  one-hot grant, registered; all zero when idle
done  output  NREQ  one-cycle completion pulse to the winner, registered
busy  output  1  high whenever state is not IDLE
count  output  CW  current shared counter value, registered

Behaviour:
Reset values:
- gnt=0, done=0, busy=0, count=0.
- State=IDLE, rr pointer ptr=0, winner index=0.
- Reset asserted mid-operation aborts immediately: no done pulse. Operation resumes from IDLE on the first clock edge after reset deasserts.

States: IDLE, COUNT, DONE.

IDLE:
- If any req bit is set, pick the winner by searching from index ptr upward with wrap (ptr, ptr+1 .. NREQ-1, 0 .. ptr-1).
- On the same edge: gnt<=onehot(winner), count<=len[winner], busy<=1, state<=COUNT.
- If no req is set, remain in IDLE with all outputs zero.

COUNT:
- If req[winner]==0 (abort): gnt<=0, count<=0, ptr<=winner+1 mod NREQ, state<=IDLE, no done.
- Else if count==0: state<=DONE, done[winner]<=1, gnt held.
- Else: count<=count-1.
- Abort takes priority over count==0 in the same cycle.

DONE:
- done pulse is visible this cycle only.
- Next edge: done<=0, gnt<=0, ptr<=winner+1 mod NREQ, state<=IDLE.

Latency: with delay L, gnt rises at edge 1 and done is high during the cycle after edge L+2, i.e. L+1 cycles after gnt rises. gnt stays high L+2 cycles in total.

Boundary conditions:
- len=0 gives done one cycle after gnt.
- len=2^CW-1 must count the full range with no wrap.
- Back-to-back requests always have exactly one IDLE cycle between grants.
- Requests arriving while busy are held off (level-sensitive, no queuing); they win later per round-robin.
- len changes after grant are ignored.
- A req drop in the DONE cycle is ignored; done still pulses.
- ptr wraps from NREQ-1 to 0.
- Never more than one gnt bit and one done bit set at once.

Decomposition:
- Package counter_share_pkg holds the state enum (IDLE, COUNT, DONE) and the function onehot(idx, NREQ).
- Sub-module down_counter(clk, reset, load, load_val[CW], dec, clr, q[CW], zero) holds the counter register.
- The arbiter FSM and round-robin pick live in counter_share_arbiter.

Test Plan:
1. Reset with req=4'b1111 held -> all outputs 0 during reset; first edge after release grants index 0 (gnt=0001, count=len[0]).
2. req=0001, len[0]=3 -> gnt=0001 at edge 1; count 3,2,1,0 on edges 1-4; done=0001 for one cycle after edge 5; gnt=0 and busy=0 after edge 6.
3. req=0101 held, len=2 each -> grants in order 0, 2, 0, 2, each separated by one IDLE cycle; done pulses in matching order.
4. After serving index 3, req=1001 -> ptr wrapped to 0, so index 0 granted before 3.
5. req[1] granted with len=7, req[1] dropped after 3 cycles -> gnt=0 and count=0 next edge, done never pulses; next grant starts search at index 2.
6. reset asserted asynchronously mid-COUNT (count=5) -> gnt, done, busy, count go 0 without a clock edge; after release, arbitration restarts from ptr=0. Also len=0 -> done one cycle after gnt.

Source files
------------

// File: rtl/counter_share_pkg.sv
// Shared types and helpers for the counter-sharing arbiter.
package counter_share_pkg;

  // Upper bound on requesters; onehot() returns this many bits and callers slice.
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One-hot vector with bit idx set; zero if idx falls outside 0..nreq-1.
  function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int nreq);
    logic [MAX_REQ-1:0] v;
    v = '0;
    if (idx >= 0 && idx < nreq && idx < MAX_REQ) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down counter backing the shared delay timer.
module down_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] q,
  output logic          zero
);

  // Counter register: clear beats load, load beats decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q <= '0;
    else if (clr)  q <= '0;
    else if (load) q <= load_val;
    else if (dec)  q <= q - CW'(1);
  end

  assign zero = (q == '0);

endmodule

// File: rtl/counter_share_arbiter.sv
// Round-robin owner of a single shared down-counting delay timer.
module counter_share_arbiter
  import counter_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [CW-1:0]     count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              state;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       winner;
  logic [IW-1:0]       pick;
  logic [IW-1:0]       ptr_next;
  logic                found;
  logic                abort;
  logic                load;
  logic                dec;
  logic                clr;
  logic                zero;
  logic [CW-1:0]       load_val;
  logic [MAX_REQ-1:0]  pick_oh;
  logic [MAX_REQ-1:0]  win_oh;

  // Round-robin search starting at ptr and wrapping past NREQ-1.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // Delay length of the candidate winner; only consumed on the grant edge.
  always_comb begin
    load_val = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(pick) == i) load_val = len[i*CW +: CW];
    end
  end

  assign pick_oh  = onehot(int'(pick), NREQ);
  assign win_oh   = onehot(int'(winner), NREQ);
  assign abort    = !req[winner];
  assign ptr_next = (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);

  assign load = (state == IDLE) && found;
  assign clr  = (state == COUNT) && abort;
  assign dec  = (state == COUNT) && !abort && !zero;

  down_counter #(.CW(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .clr      (clr),
    .q        (count),
    .zero     (zero)
  );

  // Arbiter FSM: grant, watch the shared count, pulse done, advance the pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      winner <= '0;
      gnt    <= '0;
      done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (found) begin
            winner <= pick;
            gnt    <= pick_oh[NREQ-1:0];
            state  <= COUNT;
          end else begin
            gnt <= '0;
          end
        end
        COUNT: begin
          if (abort) begin
            gnt   <= '0;
            ptr   <= ptr_next;
            state <= IDLE;
          end else if (zero) begin
            done  <= win_oh[NREQ-1:0];
            state <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
          gnt   <= '0;
          ptr   <= ptr_next;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          done  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Randomized and directed bench for counter_share_arbiter against a timeline model.
module tb_counter_share_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 4;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*CW-1:0]   len;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic                 busy;
  logic [CW-1:0]        count;

  int n_chk;
  int n_fail;

  // Timeline model: an owner is granted at elapsed=0 and everything else
  // follows from elapsed edges and the sampled length.
  bit m_act;
  int m_owner;
  int m_len;
  int m_el;
  int m_ptr;

  counter_share_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len   (len),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] exp_vec();
    logic [3:0] g, d, c;
    if (!m_act) return '0;
    g = 4'b0001 << m_owner;
    d = (m_el == m_len + 1) ? g : 4'b0000;
    c = (m_el >= m_len) ? 4'd0 : 4'(m_len - m_el);
    return {g, d, 1'b1, c};
  endfunction

  task automatic model_reset();
    m_act = 0; m_ptr = 0; m_owner = 0; m_len = 0; m_el = 0;
  endtask

  task automatic model_edge();
    int i;
    if (reset) begin
      model_reset();
    end else if (!m_act) begin
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (!m_act && req[i]) begin
          m_act = 1; m_owner = i; m_len = int'(len[i*CW +: CW]); m_el = 0;
        end
      end
    end else begin
      m_el++;
      if ((m_el <= m_len + 1 && !req[m_owner]) || m_el == m_len + 2) begin
        m_act = 0;
        m_ptr = (m_owner + 1) % NREQ;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drain();
    req = '0;
    for (int i = 0; i < 24; i++) begin
      if (!m_act) break;
      step();
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    len   = {4'd4, 4'd3, 4'd2, 4'd5};
    model_reset();
    #2;
    n_chk++;
    if ({gnt, done, busy, count} !== 13'd0) begin
      n_fail++; $display("FAIL reset_hold got=%h exp=0", {gnt, done, busy, count});
    end
    step();
    n_chk++;
    if ({gnt, done, busy, count} !== 13'd0) begin
      n_fail++; $display("FAIL reset_edge got=%h exp=0", {gnt, done, busy, count});
    end
    reset = 1'b0;
    step();
    n_chk++;
    if (gnt !== 4'b0001 || count !== 4'd5 || busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_grant gnt=%b count=%0d busy=%b exp gnt=0001 count=5 busy=1", gnt, count, busy);
    end
    n_chk++;
    if ({gnt, done, busy, count} !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model got=%h exp=%h", {gnt, done, busy, count}, exp_vec());
    end
    drain();
  endtask

  task automatic test_single();
    req = 4'b0001;
    len = {4'd0, 4'd0, 4'd0, 4'd3};
    for (int e = 1; e <= 6; e++) begin
      step();
      n_chk++;
      if ({gnt, done, busy, count} !== exp_vec()) begin
        n_fail++; $display("FAIL single e=%0d got=%h exp=%h", e, {gnt, done, busy, count}, exp_vec());
      end
      if (e <= 4) begin
        n_chk++;
        if (count !== 4'(4 - e)) begin
          n_fail++; $display("FAIL single_count e=%0d got=%0d exp=%0d", e, count, 4 - e);
        end
      end
      if (e == 5) begin
        n_chk++;
        if (done !== 4'b0001 || gnt !== 4'b0001) begin
          n_fail++; $display("FAIL single_done done=%b gnt=%b exp 0001/0001", done, gnt);
        end
      end
      if (e == 6) begin
        n_chk++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || done !== 4'b0000) begin
          n_fail++; $display("FAIL single_idle gnt=%b busy=%b done=%b exp 0/0/0", gnt, busy, done);
        end
      end
    end
    drain();
  endtask

  task automatic test_alternate();
    logic [3:0] last_done;
    int         n_done;
    int         gap;
    last_done = '0;
    n_done = 0;
    gap = 0;
    req = 4'b0101;
    len = {4'd0, 4'd2, 4'd0, 4'd2};
    for (int e = 0; e < 24; e++) begin
      step();
      n_chk++;
      if ({gnt, done, busy, count} !== exp_vec()) begin
        n_fail++; $display("FAIL alt e=%0d got=%h exp=%h", e, {gnt, done, busy, count}, exp_vec());
      end
      if (!busy) gap++;
      if (done != 0) begin
        n_chk++;
        if (done === last_done || (done !== 4'b0001 && done !== 4'b0100)) begin
          n_fail++; $display("FAIL alt_order got=%b prev=%b exp alternating 0001/0100", done, last_done);
        end
        last_done = done;
        n_done++;
      end
    end
    n_chk++;
    if (n_done < 4 || gap < 4) begin
      n_fail++; $display("FAIL alt_count dones=%0d idle=%0d exp >=4 each", n_done, gap);
    end
    drain();
  endtask

  task automatic test_wrap();
    bit seen;
    seen = 0;
    req = 4'b1000;
    len = {4'd1, 4'd0, 4'd0, 4'd1};
    for (int e = 0; e < 12 && !seen; e++) begin
      step();
      if (done == 4'b1000) seen = 1;
    end
    n_chk++;
    if (!seen) begin
      n_fail++; $display("FAIL wrap_serve3 timed out waiting for done=1000");
    end
    req = 4'b1001;
    step();
    step();
    n_chk++;
    if (gnt !== 4'b0001) begin
      n_fail++; $display("FAIL wrap_grant got=%b exp=0001", gnt);
    end
    n_chk++;
    if ({gnt, done, busy, count} !== exp_vec()) begin
      n_fail++; $display("FAIL wrap_model got=%h exp=%h", {gnt, done, busy, count}, exp_vec());
    end
    drain();
  endtask

  task automatic test_abort();
    req = 4'b0010;
    len = {4'd0, 4'd3, 4'd7, 4'd0};
    for (int e = 0; e < 4; e++) begin
      step();
      n_chk++;
      if ({gnt, done, busy, count} !== exp_vec()) begin
        n_fail++; $display("FAIL abort_run e=%0d got=%h exp=%h", e, {gnt, done, busy, count}, exp_vec());
      end
    end
    req = 4'b0101;
    step();
    n_chk++;
    if (gnt !== 4'b0000 || count !== 4'd0 || done !== 4'b0000) begin
      n_fail++; $display("FAIL abort_clear gnt=%b count=%0d done=%b exp 0/0/0", gnt, count, done);
    end
    step();
    n_chk++;
    if (gnt !== 4'b0100 || count !== 4'd3) begin
      n_fail++; $display("FAIL abort_next gnt=%b count=%0d exp 0100/3", gnt, count);
    end
    for (int e = 0; e < 8; e++) begin
      step();
      n_chk++;
      if (done[1] !== 1'b0 || {gnt, done, busy, count} !== exp_vec()) begin
        n_fail++; $display("FAIL abort_after e=%0d got=%h exp=%h", e, {gnt, done, busy, count}, exp_vec());
      end
    end
    drain();
  endtask

  task automatic test_async_reset();
    req = 4'b0001;
    len = {4'd0, 4'd0, 4'd0, 4'd9};
    step();
    for (int e = 0; e < 4; e++) step();
    n_chk++;
    if (count !== 4'd5 || gnt !== 4'b0001) begin
      n_fail++; $display("FAIL areset_pre count=%0d gnt=%b exp 5/0001", count, gnt);
    end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_chk++;
    if ({gnt, done, busy, count} !== 13'd0) begin
      n_fail++; $display("FAIL areset_immediate got=%h exp=0", {gnt, done, busy, count});
    end
    step();
    reset = 1'b0;
    req = 4'b0110;
    len = {4'd0, 4'd4, 4'd6, 4'd0};
    step();
    n_chk++;
    if (gnt !== 4'b0010 || count !== 4'd6) begin
      n_fail++; $display("FAIL areset_restart gnt=%b count=%0d exp 0010/6", gnt, count);
    end
    drain();
    req = 4'b0001;
    len = {4'd0, 4'd0, 4'd0, 4'd0};
    step();
    n_chk++;
    if (gnt !== 4'b0001 || count !== 4'd0 || done !== 4'b0000) begin
      n_fail++; $display("FAIL len0_grant gnt=%b count=%0d done=%b exp 0001/0/0000", gnt, count, done);
    end
    step();
    n_chk++;
    if (done !== 4'b0001) begin
      n_fail++; $display("FAIL len0_done got=%b exp=0001", done);
    end
    drain();
  endtask

  task automatic test_maxlen();
    req = 4'b0100;
    len = {4'd0, 4'd15, 4'd0, 4'd0};
    for (int e = 1; e <= 18; e++) begin
      step();
      n_chk++;
      if ({gnt, done, busy, count} !== exp_vec()) begin
        n_fail++; $display("FAIL maxlen e=%0d got=%h exp=%h", e, {gnt, done, busy, count}, exp_vec());
      end
      if (e == 17) begin
        n_chk++;
        if (done !== 4'b0100) begin
          n_fail++; $display("FAIL maxlen_done got=%b exp=0100", done);
        end
      end
    end
    drain();
  endtask

  task automatic test_random();
    req = '0;
    for (int e = 0; e < 600; e++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
      end
      len = 16'($urandom);
      step();
      n_chk++;
      if ({gnt, done, busy, count} !== exp_vec()) begin
        n_fail++; $display("FAIL random e=%0d req=%b got=%h exp=%h", e, req, {gnt, done, busy, count}, exp_vec());
      end
      n_chk++;
      if ($countones(gnt) > 1 || $countones(done) > 1) begin
        n_fail++; $display("FAIL random_onehot gnt=%b done=%b exp at most one bit each", gnt, done);
      end
    end
    drain();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    req    = '0;
    len    = '0;
    test_reset();
    test_single();
    test_alternate();
    test_wrap();
    test_abort();
    test_async_reset();
    test_maxlen();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
